mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL provide parameter DEPTH, default 1024, meaning memory size in 32-bit words (power of two).
REQ-002 SHALL provide parameter WAIT, default 2, meaning added wait cycles between acceptance and response (range 0-15).
REQ-003 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL provide port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL provide port req_valid  input  1  initiator presents a request.
REQ-006 SHALL provide port req_ready  output  1  responder can accept a request this cycle.
REQ-007 SHALL provide port req_we  input  1  1 = write, 0 = read.
REQ-008 SHALL provide port req_sel  input  4  byte enables for writes; sel[i] covers bits 8i+7:8i.
REQ-009 SHALL provide port req_addr  input  32  byte address.
REQ-010 SHALL provide port req_wdata  input  32  write data.
REQ-011 SHALL provide port resp_valid  output  1  one-cycle response strobe.
REQ-012 SHALL provide port resp_rdata  output  32  read data, valid only with resp_valid.
REQ-013 SHALL provide port resp_err  output  1  request rejected, valid only with resp_valid.

Function
REQ-014 SHALL hold storage in an array named memory, DEPTH words, word index = req_addr[log2(DEPTH)+1:2], loadable by the bench via $readmemb.
REQ-015 SHALL implement states IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-016 SHALL accept a request on a rising edge where req_valid && req_ready, latching we, addr, sel, wdata.
REQ-017 SHALL transition IDLE->WAIT on acceptance with wait counter loaded with WAIT; IDLE->RESP directly when WAIT = 0.
REQ-018 SHALL decrement the counter each cycle in WAIT and move to RESP on the edge where the counter reaches 1 (i.e. exactly WAIT cycles spent in WAIT).
REQ-019 SHALL assert resp_valid for exactly one cycle in RESP, then return to IDLE; response therefore appears WAIT+1 cycles after the accepting edge.
REQ-020 SHALL flag error when req_addr[1:0] != 0 or req_addr >= 4*DEPTH; errored requests never modify memory and return resp_rdata = 0, resp_err = 1.
REQ-021 SHALL commit a valid write on the accepting edge, updating only enabled bytes; write responses carry resp_rdata = 0, resp_err = 0.
REQ-022 SHALL return for a valid read the full 32-bit word (req_sel ignored) as stored at the accepting edge.
REQ-023 SHALL treat a write with req_sel = 0000 as a successful no-op.
REQ-024 SHALL ignore req_valid while not in IDLE; the initiator holds the request until accepted.
REQ-025 SHALL allow back-to-back transactions: the cycle after RESP is IDLE and may accept immediately.
REQ-026 SHALL drive resp_rdata and resp_err to 0 whenever resp_valid = 0.

Reset
REQ-027 SHALL on rst = 0 immediately force state IDLE, counter 0, req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0.
REQ-028 SHALL NOT clear memory on reset; contents survive reset.
REQ-029 SHALL on reset mid-transaction drop the pending response (no resp_valid after release); a write already committed at acceptance remains.
REQ-030 SHALL ignore req_valid while rst = 0.

Verification
REQ-031 Read: memory[0] = 0x34011100, WAIT = 2, read addr 0x0 -> resp_valid 3 cycles after acceptance, rdata 0x34011100, err 0, req_ready low for those 3 cycles.
REQ-032 Byte write: memory[1] = 0x11223344, write addr 0x4 sel 0101 wdata 0xAABBCCDD, then read 0x4 -> rdata 0x11BB33DD.
REQ-033 Errors: read addr 0x2 and read addr 0x1000 (DEPTH 1024) -> resp_err 1, rdata 0; write to 0x1000 leaves all memory unchanged.
REQ-034 WAIT = 0: four back-to-back reads of 0x0,0x4,0x8,0xC -> one response per two cycles, data in order.
REQ-035 Reset mid-WAIT: accept write 0x8 = 0xDEADBEEF, assert rst during WAIT -> no resp_valid, req_ready 1 after release, subsequent read 0x8 returns 0xDEADBEEF.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: single-outstanding word memory responder with fixed response latency.
// Writes commit on the accepting edge; reads return the word captured at that edge.
module mem_responder #(
   parameter int DEPTH = 1024,
   parameter int WAIT  = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [3:0]  req_sel,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);
   localparam int         AW       = $clog2(DEPTH);
   localparam logic [3:0] WAIT_CNT = 4'(WAIT);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic [31:0]   memory [DEPTH];
   logic [AW-1:0] idx;
   logic          accept;
   logic          addr_err;

   assign idx = req_addr[AW+1:2];
   // DEPTH is a power of two, so any set bit above the word index is out of range
   assign addr_err = (req_addr[1:0] != 2'b00) || (req_addr[31:AW+2] != '0);
   assign accept   = rst && req_valid && (state_q == ST_IDLE);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               err_d   = addr_err;
               rdata_d = (req_we || addr_err) ? '0 : memory[idx];
               cnt_d   = WAIT_CNT;
               state_d = (WAIT_CNT == 4'd0) ? ST_RESP : ST_WAIT;
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = ST_RESP;
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Storage is deliberately outside the reset domain so contents survive reset
   always_ff @(posedge clk) begin
      if (accept && req_we && !addr_err) begin
         for (int i = 0; i < 4; i++) begin
            if (req_sel[i]) memory[idx][8*i +: 8] <= req_wdata[8*i +: 8];
         end
      end
   end

   assign req_ready  = (state_q == ST_IDLE);
   assign resp_valid = (state_q == ST_RESP);
   assign resp_rdata = resp_valid ? rdata_q : '0;
   assign resp_err   = resp_valid && err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (WAIT=2 and WAIT=0) driven from request queues
// and compared every cycle against a transaction-level model of latency and memory contents.
module tb_mem_responder;
   localparam int DEPTH = 1024;
   localparam int NI    = 2;
   localparam int LIMIT = 20000;

   typedef struct {
      bit          idle;
      logic        we;
      logic [3:0]  sel;
      logic [31:0] addr;
      logic [31:0] wdata;
      bit          lit;
      logic [31:0] lit_data;
      logic        lit_err;
      bit          rst_after;
   } req_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid  [NI];
   logic        req_ready  [NI];
   logic        req_we     [NI];
   logic [3:0]  req_sel    [NI];
   logic [31:0] req_addr   [NI];
   logic [31:0] req_wdata  [NI];
   logic        resp_valid [NI];
   logic [31:0] resp_rdata [NI];
   logic        resp_err   [NI];

   mem_responder #(.DEPTH(DEPTH), .WAIT(2)) dut0 (
      .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_we(req_we[0]), .req_sel(req_sel[0]), .req_addr(req_addr[0]),
      .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]),
      .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]));

   mem_responder #(.DEPTH(DEPTH), .WAIT(0)) dut1 (
      .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_we(req_we[1]), .req_sel(req_sel[1]), .req_addr(req_addr[1]),
      .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]),
      .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]));

   initial forever #5 clk = ~clk;

   // Model state: edges counted from reset release; a request accepted at edge n
   // responds in the cycle after edge n+W and the responder is idle again after edge n+W+1.
   longint      cyc;
   longint      free_edge [NI];
   longint      resp_edge [NI];
   bit          pend      [NI];
   bit          accepted  [NI];
   logic [31:0] exp_data  [NI];
   logic        exp_err   [NI];
   req_t        cur       [NI];
   req_t        rq        [NI][$];
   logic [31:0] ref_mem   [NI][DEPTH];
   int          rst_hold;
   int          n_total;
   int          n_pass;

   function automatic int wait_of(int k);
      return (k == 0) ? 2 : 0;
   endfunction

   function automatic logic is_err(logic [31:0] a);
      return (a % 4 != 0) || (a >= 32'(4 * DEPTH));
   endfunction

   function automatic logic [31:0] init_val(int i);
      if (i == 0) return 32'h3401_1100;
      if (i == 1) return 32'h1122_3344;
      return 32'hC0DE_0000 | 32'(i);
   endfunction

   function automatic req_t mk(logic we, logic [3:0] sel, logic [31:0] addr, logic [31:0] wdata,
                               bit lit, logic [31:0] ld, logic le, bit ra);
      req_t r;
      r.idle = 1'b0; r.we = we; r.sel = sel; r.addr = addr; r.wdata = wdata;
      r.lit = lit; r.lit_data = ld; r.lit_err = le; r.rst_after = ra;
      return r;
   endfunction

   task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s[%0d] cyc=%0d got=%h want=%h", nm, k, cyc, act, exp);
   endtask

   task automatic model_reset();
      for (int k = 0; k < NI; k++) begin
         pend[k] = 1'b0;
         free_edge[k] = 0;
      end
   endtask

   task automatic model_edge();
      for (int k = 0; k < NI; k++) begin
         accepted[k] = 1'b0;
         if (rst && req_valid[k] && cyc >= free_edge[k] + 1) begin
            logic e;
            int   w;
            e = is_err(req_addr[k]);
            w = int'(req_addr[k] / 4) % DEPTH;
            if (!e && req_we[k])
               for (int b = 0; b < 4; b++)
                  if (req_sel[k][b]) ref_mem[k][w][8*b +: 8] = req_wdata[k][8*b +: 8];
            exp_data[k]  = (e || req_we[k]) ? 32'h0 : ref_mem[k][w];
            exp_err[k]   = e;
            pend[k]      = 1'b1;
            resp_edge[k] = cyc + wait_of(k);
            free_edge[k] = cyc + wait_of(k) + 1;
            accepted[k]  = 1'b1;
         end
      end
   endtask

   task automatic check_all();
      for (int k = 0; k < NI; k++) begin
         logic ev;
         ev = pend[k] && (resp_edge[k] == cyc);
         chk("req_ready", k, 32'(req_ready[k]), 32'(cyc >= free_edge[k]));
         chk("resp_valid", k, 32'(resp_valid[k]), 32'(ev));
         chk("resp_rdata", k, resp_rdata[k], ev ? exp_data[k] : 32'h0);
         chk("resp_err", k, 32'(resp_err[k]), 32'(ev && exp_err[k]));
         if (ev) begin
            if (cur_lit_pending(k)) begin
               chk("lit_rdata", k, resp_rdata[k], lit_data_q[k]);
               chk("lit_err", k, 32'(resp_err[k]), 32'(lit_err_q[k]));
            end
            pend[k] = 1'b0;
         end
      end
   endtask

   // Literal expectations travel with the accepted request
   bit          lit_q      [NI];
   logic [31:0] lit_data_q [NI];
   logic        lit_err_q  [NI];

   function automatic bit cur_lit_pending(int k);
      return lit_q[k];
   endfunction

   task automatic capture_lit();
      for (int k = 0; k < NI; k++)
         if (accepted[k]) begin
            lit_q[k]      = cur[k].lit;
            lit_data_q[k] = cur[k].lit_data;
            lit_err_q[k]  = cur[k].lit_err;
         end
   endtask

   task automatic handle_reset();
      if (rst_hold > 0) begin
         rst_hold--;
         if (rst_hold == 0) rst = 1'b1;
      end
      if (accepted[0] && cur[0].rst_after) begin
         rst = 1'b0;
         rst_hold = 2;
         model_reset();
         #1;
         for (int k = 0; k < NI; k++) begin
            chk("rst_ready", k, 32'(req_ready[k]), 32'h1);
            chk("rst_valid", k, 32'(resp_valid[k]), 32'h0);
            chk("rst_rdata", k, resp_rdata[k], 32'h0);
            chk("rst_err", k, 32'(resp_err[k]), 32'h0);
         end
      end
   endtask

   task automatic drive();
      for (int k = 0; k < NI; k++) begin
         if (!req_valid[k] || accepted[k]) begin
            if (rq[k].size() > 0) begin
               cur[k]       = rq[k].pop_front();
               req_valid[k] = !cur[k].idle;
               req_we[k]    = cur[k].we;
               req_sel[k]   = cur[k].sel;
               req_addr[k]  = cur[k].addr;
               req_wdata[k] = cur[k].wdata;
            end else begin
               req_valid[k] = 1'b0;
            end
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      cyc++;
      model_edge();
      capture_lit();
      @(negedge clk);
      check_all();
      handle_reset();
      drive();
   endtask

   initial begin
      req_t r;
      n_total = 0; n_pass = 0; cyc = 0; rst_hold = 0;
      rst = 1'b0;
      for (int k = 0; k < NI; k++) begin
         req_valid[k] = 1'b0; req_we[k] = 1'b0; req_sel[k] = '0;
         req_addr[k] = '0; req_wdata[k] = '0;
         accepted[k] = 1'b0; lit_q[k] = 1'b0;
      end
      model_reset();

      for (int k = 0; k < NI; k++)
         for (int i = 0; i < 16; i++)
            rq[k].push_back(mk(1'b1, 4'hF, 32'(4 * i), init_val(i), 1'b1, 32'h0, 1'b0, 1'b0));

      rq[0].push_back(mk(1'b0, 4'h0, 32'h0,    32'h0,        1'b1, 32'h3401_1100, 1'b0, 1'b0));
      rq[0].push_back(mk(1'b1, 4'h5, 32'h4,    32'hAABB_CCDD, 1'b1, 32'h0,        1'b0, 1'b0));
      rq[0].push_back(mk(1'b0, 4'h0, 32'h4,    32'h0,        1'b1, 32'h11BB_33DD, 1'b0, 1'b0));
      rq[0].push_back(mk(1'b0, 4'hF, 32'h2,    32'h0,        1'b1, 32'h0,        1'b1, 1'b0));
      rq[0].push_back(mk(1'b0, 4'hF, 32'h1000, 32'h0,        1'b1, 32'h0,        1'b1, 1'b0));
      rq[0].push_back(mk(1'b1, 4'hF, 32'h1000, 32'hFFFF_FFFF, 1'b1, 32'h0,        1'b1, 1'b0));
      rq[0].push_back(mk(1'b0, 4'h0, 32'h0,    32'h0,        1'b1, 32'h3401_1100, 1'b0, 1'b0));
      rq[0].push_back(mk(1'b1, 4'h0, 32'h8,    32'h1234_5678, 1'b1, 32'h0,        1'b0, 1'b0));
      rq[0].push_back(mk(1'b0, 4'h0, 32'h8,    32'h0,        1'b1, 32'hC0DE_0002, 1'b0, 1'b0));
      rq[0].push_back(mk(1'b1, 4'hF, 32'h8,    32'hDEAD_BEEF, 1'b0, 32'h0,        1'b0, 1'b1));
      rq[0].push_back(mk(1'b0, 4'h0, 32'h8,    32'h0,        1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0));

      rq[1].push_back(mk(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h3401_1100, 1'b0, 1'b0));
      rq[1].push_back(mk(1'b0, 4'h0, 32'h4, 32'h0, 1'b1, 32'h1122_3344, 1'b0, 1'b0));
      rq[1].push_back(mk(1'b0, 4'h0, 32'h8, 32'h0, 1'b1, 32'hC0DE_0002, 1'b0, 1'b0));
      rq[1].push_back(mk(1'b0, 4'h0, 32'hC, 32'h0, 1'b1, 32'hC0DE_0003, 1'b0, 1'b0));

      for (int k = 0; k < NI; k++)
         for (int n = 0; n < 200; n++) begin
            logic [31:0] a;
            int          sel_kind;
            sel_kind = $urandom_range(0, 9);
            if (sel_kind == 0) a = 32'(4 * $urandom_range(0, 15) + $urandom_range(1, 3));
            else if (sel_kind == 1) begin
               a = $urandom;
               if (a < 32'(4 * DEPTH)) a = a + 32'(4 * DEPTH);
            end else a = 32'(4 * $urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) begin
               r = mk(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
               r.idle = 1'b1;
               rq[k].push_back(r);
            end
            rq[k].push_back(mk(1'($urandom), 4'($urandom), a, $urandom, 1'b0, 32'h0, 1'b0,
                               (k == 0) && ($urandom_range(0, 39) == 0)));
         end

      #1;
      for (int k = 0; k < NI; k++) begin
         chk("init_ready", k, 32'(req_ready[k]), 32'h1);
         chk("init_valid", k, 32'(resp_valid[k]), 32'h0);
         chk("init_rdata", k, resp_rdata[k], 32'h0);
         chk("init_err", k, 32'(resp_err[k]), 32'h0);
      end
      @(negedge clk);
      rst = 1'b1;
      drive();

      while ((rq[0].size() > 0 || rq[1].size() > 0 || req_valid[0] || req_valid[1] ||
              pend[0] || pend[1] || rst_hold > 0) && cyc < LIMIT)
         step();
      if (cyc >= LIMIT) begin
         n_total++;
         $display("FAIL timeout cyc=%0d got=busy want=drained", cyc);
      end
      repeat (3) step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
